// File: rtl/tl_async_pkg.sv
// tl_async_pkg: shared widths, payload layout and synchronizer default for the TL async source
package tl_async_pkg;
   localparam int OPCODE_W = 3;
   localparam int PARAM_W = 3;
   localparam int SIZE_W = 2;
   localparam int SOURCE_W = 1;
   localparam int ADDRESS_W = 9;
   localparam int MASK_W = 4;
   localparam int DATA_W = 32;
   localparam int PAYLOAD_W = 55;
   localparam int CORRUPT_OFF = 0;
   localparam int DATA_OFF = 1;
   localparam int MASK_OFF = 33;
   localparam int ADDRESS_OFF = 37;
   localparam int SOURCE_OFF = 46;
   localparam int SIZE_OFF = 47;
   localparam int PARAM_OFF = 49;
   localparam int OPCODE_OFF = 52;
   localparam int SYNC_STAGES_DEFAULT = 3;
endpackage

// File: rtl/tl_async_sync.sv
// tl_async_sync: n-stage 1-bit synchronizer with synchronous reset to 0
module tl_async_sync #(
   parameter int N = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [N-1:0] s;
   always_ff @(posedge clock)
      if (reset) s <= '0;
      else s <= {s[N-2:0], d};
   assign q = s[N-1];
endmodule

// File: rtl/tl_async_source.sv
// tl_async_source: single-slot TileLink async crossing source with ridx/sink-alive synchronizers
module tl_async_source
   import tl_async_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  enq_ready,
   input  logic                  enq_valid,
   input  logic [OPCODE_W-1:0]   enq_opcode,
   input  logic [PARAM_W-1:0]    enq_param,
   input  logic [SIZE_W-1:0]     enq_size,
   input  logic [SOURCE_W-1:0]   enq_source,
   input  logic [ADDRESS_W-1:0]  enq_address,
   input  logic [MASK_W-1:0]     enq_mask,
   input  logic [DATA_W-1:0]     enq_data,
   input  logic                  enq_corrupt,
   output logic [PAYLOAD_W-1:0]  async_mem,
   output logic                  async_widx,
   input  logic                  async_ridx,
   output logic                  async_safe_widx_valid,
   output logic                  async_safe_source_reset_n,
   input  logic                  async_safe_ridx_valid,
   input  logic                  async_safe_sink_reset_n
);
   logic ridx_s, sink_ready, unused_sink_reset_n;
   logic [PAYLOAD_W-1:0] payload;
   tl_async_sync #(.N(SYNC_STAGES)) u_ridx_sync (
      .clock(clock), .reset(reset), .d(async_ridx), .q(ridx_s)
   );
   tl_async_sync #(.N(SYNC_STAGES)) u_valid_sync (
      .clock(clock), .reset(reset), .d(async_safe_ridx_valid), .q(sink_ready)
   );
   assign unused_sink_reset_n = async_safe_sink_reset_n;
   assign payload = {enq_opcode, enq_param, enq_size, enq_source, enq_address, enq_mask, enq_data, enq_corrupt};
   assign enq_ready = sink_ready & (async_widx == ridx_s);
   assign async_safe_source_reset_n = ~reset;
   always_ff @(posedge clock)
      if (reset) begin
         async_widx <= 1'b0;
         async_mem <= '0;
         async_safe_widx_valid <= 1'b0;
      end else begin
         async_safe_widx_valid <= 1'b1;
         if (!sink_ready) async_widx <= 1'b0;
         else if (enq_valid && enq_ready) begin
            async_widx <= ~async_widx;
            async_mem <= payload;
         end
      end
endmodule

// File: tb/tb_tl_async_source.sv
// tb_tl_async_source: directed self-checking bench for tl_async_source
module tb_tl_async_source;
   logic clock = 1'b0, reset = 1'b1;
   logic enq_ready, enq_valid = 1'b0;
   logic [2:0] enq_opcode = '0, enq_param = '0;
   logic [1:0] enq_size = '0;
   logic [0:0] enq_source = '0;
   logic [8:0] enq_address = '0;
   logic [3:0] enq_mask = '0;
   logic [31:0] enq_data = '0;
   logic enq_corrupt = 1'b0;
   logic [54:0] async_mem;
   logic async_widx, async_ridx = 1'b0;
   logic async_safe_widx_valid, async_safe_source_reset_n;
   logic async_safe_ridx_valid = 1'b1, async_safe_sink_reset_n = 1'b1;
   int checks = 0, errors = 0;
   localparam logic [54:0] BEAT1 = 55'h41_34BF_BD5B_7DDE;
   localparam logic [54:0] BEAT2 = 55'h14_C062_0000_0003;

   tl_async_source dut (
      .clock(clock), .reset(reset), .enq_ready(enq_ready), .enq_valid(enq_valid),
      .enq_opcode(enq_opcode), .enq_param(enq_param), .enq_size(enq_size),
      .enq_source(enq_source), .enq_address(enq_address), .enq_mask(enq_mask),
      .enq_data(enq_data), .enq_corrupt(enq_corrupt), .async_mem(async_mem),
      .async_widx(async_widx), .async_ridx(async_ridx),
      .async_safe_widx_valid(async_safe_widx_valid),
      .async_safe_source_reset_n(async_safe_source_reset_n),
      .async_safe_ridx_valid(async_safe_ridx_valid),
      .async_safe_sink_reset_n(async_safe_sink_reset_n)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic set_beat1();
      enq_opcode = 3'd4; enq_param = 3'd0; enq_size = 2'd2; enq_source = 1'b0;
      enq_address = 9'h1A5; enq_mask = 4'hF; enq_data = 32'hDEADBEEF; enq_corrupt = 1'b0;
   endtask

   task automatic set_beat2();
      enq_opcode = 3'd1; enq_param = 3'd2; enq_size = 2'd1; enq_source = 1'b1;
      enq_address = 9'h003; enq_mask = 4'h1; enq_data = 32'h1; enq_corrupt = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(5);
      checks++; if (async_widx !== 1'b0) begin errors++; $display("FAIL rst_widx got %b exp 0", async_widx); end
      checks++; if (async_mem !== 55'd0) begin errors++; $display("FAIL rst_mem got %h exp 0", async_mem); end
      checks++; if (async_safe_widx_valid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b exp 0", async_safe_widx_valid); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", enq_ready); end
      checks++; if (async_safe_source_reset_n !== 1'b0) begin errors++; $display("FAIL rst_srcn got %b exp 0", async_safe_source_reset_n); end
      reset = 1'b0;
      #1;
      checks++; if (async_safe_source_reset_n !== 1'b1) begin errors++; $display("FAIL srcn_rel got %b exp 1", async_safe_source_reset_n); end
      tick();
      checks++; if (async_safe_widx_valid !== 1'b1) begin errors++; $display("FAIL wvalid_rel got %b exp 1", async_safe_widx_valid); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL ready_c1 got %b exp 0", enq_ready); end
      tick();
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL ready_c2 got %b exp 0", enq_ready); end
      tick();
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL ready_c3 got %b exp 1", enq_ready); end
   endtask

   task automatic test_accept();
      set_beat1();
      enq_valid = 1'b1;
      tick();
      enq_valid = 1'b0;
      checks++; if (async_mem !== BEAT1) begin errors++; $display("FAIL acc_mem got %h exp %h", async_mem, BEAT1); end
      checks++; if (async_widx !== 1'b1) begin errors++; $display("FAIL acc_widx got %b exp 1", async_widx); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL acc_ready got %b exp 0", enq_ready); end
   endtask

   task automatic test_ridx_return();
      async_ridx = 1'b1;
      tick(2);
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL ret_early got %b exp 0", enq_ready); end
      tick();
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL ret_ready got %b exp 1", enq_ready); end
      set_beat2();
      enq_valid = 1'b1;
      tick();
      enq_valid = 1'b0;
      checks++; if (async_widx !== 1'b0) begin errors++; $display("FAIL b2_widx got %b exp 0", async_widx); end
      checks++; if (async_mem !== BEAT2) begin errors++; $display("FAIL b2_mem got %h exp %h", async_mem, BEAT2); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL b2_ready got %b exp 0", enq_ready); end
   endtask

   task automatic test_back_to_back_hold();
      int acc = 0;
      async_ridx = 1'b0;
      tick(3);
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL hold_pre got %b exp 1", enq_ready); end
      set_beat1();
      enq_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (enq_ready) acc++;
         tick();
         if (acc > 0) enq_data = 32'h12345678;
      end
      enq_valid = 1'b0;
      checks++; if (acc !== 1) begin errors++; $display("FAIL hold_count got %0d exp 1", acc); end
      checks++; if (async_mem !== BEAT1) begin errors++; $display("FAIL hold_mem got %h exp %h", async_mem, BEAT1); end
      checks++; if (async_widx !== 1'b1) begin errors++; $display("FAIL hold_widx got %b exp 1", async_widx); end
   endtask

   task automatic test_sink_drop();
      set_beat2();
      enq_valid = 1'b1;
      async_safe_ridx_valid = 1'b0;
      tick(3);
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got %b exp 0", enq_ready); end
      checks++; if (async_widx !== 1'b1) begin errors++; $display("FAIL drop_widx3 got %b exp 1", async_widx); end
      tick();
      checks++; if (async_widx !== 1'b0) begin errors++; $display("FAIL drop_widx4 got %b exp 0", async_widx); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL drop_gate got %b exp 0", enq_ready); end
      tick(3);
      checks++; if (async_widx !== 1'b0) begin errors++; $display("FAIL drop_noacc got %b exp 0", async_widx); end
      checks++; if (async_mem !== BEAT1) begin errors++; $display("FAIL drop_mem got %h exp %h", async_mem, BEAT1); end
      enq_valid = 1'b0;
      async_safe_ridx_valid = 1'b1;
      tick(2);
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL up_early got %b exp 0", enq_ready); end
      tick();
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL up_ready got %b exp 1", enq_ready); end
   endtask

   task automatic test_reset_mid();
      set_beat2();
      enq_valid = 1'b1;
      tick();
      enq_valid = 1'b0;
      checks++; if (async_widx !== 1'b1) begin errors++; $display("FAIL mid_widx got %b exp 1", async_widx); end
      reset = 1'b1;
      tick();
      checks++; if (async_mem !== 55'd0) begin errors++; $display("FAIL mid_mem got %h exp 0", async_mem); end
      checks++; if (async_widx !== 1'b0) begin errors++; $display("FAIL mid_widx_rst got %b exp 0", async_widx); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", enq_ready); end
      checks++; if (async_safe_widx_valid !== 1'b0) begin errors++; $display("FAIL mid_wvalid got %b exp 0", async_safe_widx_valid); end
      reset = 1'b0;
      tick(3);
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL mid_recover got %b exp 1", enq_ready); end
   endtask

   initial begin
      test_reset();
      test_accept();
      test_ridx_return();
      test_back_to_back_hold();
      test_sink_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tl_async_source.md
TL_ASYNC_SOURCE -- requirements
Module: tl_async_source

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clock and reset.
REQ-002 Ports SHALL be:
- clock  in  1  sole clock
- reset  in  1  synchronous reset, active-high
- enq_ready  out  1  slot free and sink alive
- enq_valid  in  1  beat offered
- enq_opcode  in  3
- enq_param  in  3
- enq_size  in  2
- enq_source  in  1
- enq_address  in  9
- enq_mask  in  4
- enq_data  in  32
- enq_corrupt  in  1
- async_mem  out  55  payload register toward the sink domain
- async_widx  out  1  write index (gray == binary at 1 bit)
- async_ridx  in  1  sink read index, asynchronous
- async_safe_widx_valid  out  1  source-alive flag
- async_safe_source_reset_n  out  1  source reset indication
- async_safe_ridx_valid  in  1  sink-alive flag, asynchronous
- async_safe_sink_reset_n  in  1  sink reset indication, asynchronous
REQ-003 Parameter SYNC_STAGES, default 3, SHALL set the synchronizer depth (legal 2..4).

Function
REQ-004 async_mem SHALL pack the fields as {opcode[54:52], param[51:49], size[48:47], source[46], address[45:37], mask[36:33], data[32:1], corrupt[0]}.
REQ-005 Queue depth SHALL be 1; widx SHALL toggle once per accepted beat.
REQ-006 async_ridx SHALL pass through a SYNC_STAGES-flop synchronizer (reset 0) to give ridx_s.
REQ-007 async_safe_ridx_valid SHALL pass through a SYNC_STAGES-flop synchronizer (reset 0) to give sink_ready.
REQ-008 enq_ready SHALL be 1 exactly when sink_ready=1 and widx==ridx_s (slot empty).
REQ-009 On enq_valid & enq_ready at an edge, async_mem SHALL load the packed payload and widx SHALL invert, both in that same edge.
REQ-010 async_mem SHALL hold its value whenever no beat is accepted; the sink reads it asynchronously.
REQ-011 When sink_ready=0, widx SHALL be forced to 0 on the next edge and no beat SHALL be accepted (sink-reset recovery).
REQ-012 enq_valid while enq_ready=0 SHALL have no effect; the producer holds the beat until accepted.
REQ-013 async_safe_widx_valid SHALL be a register that goes 0 in reset and 1 on the first edge after reset deasserts.
REQ-014 async_safe_source_reset_n SHALL equal ~reset, combinationally.
REQ-015 async_safe_sink_reset_n SHALL be ignored by datapath logic; it is only a monitoring input.
REQ-016 Latency: a beat accepted at edge N SHALL be visible on async_widx/async_mem after edge N; the next acceptance is earliest SYNC_STAGES edges after the sink's ridx toggles.

Reset
REQ-017 In reset the outputs SHALL be: widx=0, async_mem=0, async_safe_widx_valid=0, all synchronizer flops=0, enq_ready=0.
REQ-018 Reset asserted mid-transfer SHALL discard the held beat; after reset, widx=0 and the sink must also reset (detected via async_safe_ridx_valid dropping).

Structure
REQ-019 A shared package tl_async_pkg SHALL hold the field widths, the 55-bit payload width, the bit offsets of REQ-004, and SYNC_STAGES_DEFAULT=3.
REQ-020 One sub-module, tl_async_sync (N-stage 1-bit synchronizer, sync reset to 0), SHALL be instantiated twice.

Verification
REQ-021 Reset 5 cycles, async_safe_ridx_valid=1, async_ridx=0 -> enq_ready=1 on cycle 3 after release; async_safe_widx_valid=1 one cycle after release.
REQ-022 Accept opcode=4, address=0x1A5, mask=0xF, data=0xDEADBEEF, corrupt=0 -> async_mem=0x...(packed per REQ-004), async_widx=1, enq_ready=0 next cycle.
REQ-023 With widx=1, toggle async_ridx 0->1 -> enq_ready returns to 1 exactly 3 edges later; a second beat sets widx=0.
REQ-024 Hold enq_valid=1 with ridx static for 20 cycles -> only one acceptance; async_mem unchanged.
REQ-025 Drop async_safe_ridx_valid with widx=1 -> after 3 edges enq_ready=0, and widx=0 one edge later; raise it again -> enq_ready=1 after 3 edges.
REQ-026 Assert reset one cycle after acceptance -> async_mem=0, widx=0, enq_ready=0 during reset.
